aqua_dispense_ctrl: RTL and testbench
=====================================

// Module: aqua_dispense_ctrl
// PURPOSE
//  Downstream actuator stage of the Smart-Aqua vending FSM. Consumes its per-cycle vend strobe and
//  change code, queues each one as a job, and runs the outputs for each job in order: the bottle
//  motor (bottle-sensor handshake plus timeout), then the 5-rs coin-return solenoid pulses.
//  Tracks bottle stock and converts an unservable vend (sold out or motor timeout) into a full refund.
// PARAMETERS
//  QDEPTH        4    job FIFO depth (power of 2, >=2)
//  STOCK_INIT    20   bottle count loaded at reset and on restock (<=255)
//  PRICE_COINS   3    5-rs coins refunded for an unservable vend (15 rs)
//  MOTOR_TMO     200  max motor-on cycles waiting for bottle_seen
//  SOL_ON        8    solenoid high cycles per coin
//  SOL_OFF       8    solenoid low gap cycles after each coin
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous active-high reset
//  vend           in   1  bottle owed this cycle (vending FSM out)
//  change_code    in   2  00 none, 01 = 5 rs (1 coin), 10 = 10 rs (2 coins), 11 = illegal
//  bottle_seen    in   1  drop sensor; 1 = bottle has left the chute
//  restock        in   1  1-cycle pulse: reload stock to STOCK_INIT
//  motor_on       out  1  bottle motor drive
//  coin_sol       out  1  coin-return solenoid drive
//  busy           out  1  FSM not in IDLE or FIFO not empty
//  job_done       out  1  1-cycle pulse at job completion
//  stock          out  8  bottles remaining
//  sold_out       out  1  stock == 0
//  fault_tmo      out  1  sticky: a motor timeout occurred
//  overflow       out  1  sticky: a job was dropped (FIFO full or code 11)
// BEHAVIOUR
//  - Reset: all outputs 0 except stock=STOCK_INIT (sold_out=0 if STOCK_INIT>0). FIFO emptied,
//    FSM -> IDLE. Reset mid-job drops motor and solenoid on that same edge; no completion pulse.
//  - Enqueue: any cycle with vend==1 or change_code!=00 pushes one job {vend, coins}; coins from
//    the code table. change_code==11: job not pushed, overflow set, even when vend==1.
//  - FIFO full at a push: job dropped, overflow set. A push and a pop in the same cycle on a full
//    FIFO are both accepted.
//  - FSM states: IDLE, POP, MOTOR, COIN_HI, COIN_LO, DONE.
//  - IDLE: if the FIFO is non-empty -> POP (1 cycle). POP latches the job and computes pay = coins.
//      - vend and stock>0: -> MOTOR.
//      - vend and stock==0: pay += PRICE_COINS. Next state is COIN_HI if pay>0, else DONE.
//      - no vend: next state is COIN_HI if pay>0, else DONE.
//  - MOTOR: motor_on=1, and a cycle counter runs from 0.
//      - bottle_seen sampled 1: stock decrements, -> COIN_HI if pay>0, else DONE.
//      - Counter reaches MOTOR_TMO-1 without bottle_seen: fault_tmo set, pay += PRICE_COINS,
//        stock unchanged, -> COIN_HI.
//      - bottle_seen in the timeout cycle counts as success.
//  - COIN_HI: coin_sol=1 for SOL_ON cycles -> COIN_LO. COIN_LO: coin_sol=0 for SOL_OFF cycles,
//    pay decrements; -> COIN_HI if pay still >0, else DONE. pay max 5 (3-bit).
//  - DONE: job_done=1 for one cycle -> IDLE. Back-to-back jobs: IDLE->POP costs 2 cycles.
//  - motor_on and coin_sol are Moore outputs (registered from state); never high together.
//  - Stock: restock overrides a same-cycle decrement. Stock saturates at 0.
//  - sold_out = (stock==0), combinational from the register.
//  - Sticky flags clear only on rst.
// STRUCTURE
//  - aqua_pkg: change-code constants (CHG_NONE, CHG_5, CHG_10, CHG_BAD), the coins-per-code
//    function, and the dispense state enum; the vending FSM shares the same pkg.
//  - Sub-module aqua_job_fifo: synchronous FIFO parameterised by width and depth, with full/empty
//    flags and a simultaneous push/pop rule. The FSM, counters and stock stay in the top module.
// TESTING
//  1. vend=1, code 01 for one cycle; bottle_seen raised 5 cycles into MOTOR -> motor_on 5 cycles,
//     stock 20->19, one 8-high/8-low solenoid pulse, job_done once.
//  2. Code 10 only -> no motor, two solenoid pulses, stock unchanged.
//  3. Load stock to 0 via STOCK_INIT=0; vend=1, code 00 -> sold_out=1, no motor, 3 coin pulses.
//  4. vend=1, bottle_seen held 0 -> motor_on for exactly 200 cycles, fault_tmo=1, 3 pulses, stock
//     unchanged.
//  5. 6 consecutive push cycles while busy -> 4 queued (or 5 if a pop coincides), overflow=1,
//     jobs complete in order.
//  6. Assert rst mid-COIN_HI -> coin_sol=0 next edge, FIFO empty, stock=STOCK_INIT, flags 0,
//     no job_done.

Source files
------------

// File: rtl/aqua_pkg.sv
// Shared Smart-Aqua definitions: change codes, job bundle,
// dispense state encoding and the coins-per-code decoder.
package aqua_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_BAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_MOTOR,
    ST_COIN_HI,
    ST_COIN_LO,
    ST_DONE
  } disp_state_e;

  typedef struct packed {
    logic       vend;
    logic [1:0] coins;
  } job_t;

  function automatic logic [1:0] coins_of(input logic [1:0] code);
    logic [1:0] n;
    n = 2'd0;
    unique case (code)
      CHG_5:   n = 2'd1;
      CHG_10:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aqua_dispense_ctrl_if.sv
// Vend-side strobes in, actuator drives and status out.
// master = vending FSM / sensors, slave = dispense stage.
interface aqua_dispense_ctrl_if;

  logic       vend;
  logic [1:0] change_code;
  logic       bottle_seen;
  logic       restock;
  logic       motor_on;
  logic       coin_sol;
  logic       busy;
  logic       job_done;
  logic [7:0] stock;
  logic       sold_out;
  logic       fault_tmo;
  logic       overflow;

  modport master (
    output vend,
    output change_code,
    output bottle_seen,
    output restock,
    input  motor_on,
    input  coin_sol,
    input  busy,
    input  job_done,
    input  stock,
    input  sold_out,
    input  fault_tmo,
    input  overflow
  );

  modport slave (
    input  vend,
    input  change_code,
    input  bottle_seen,
    input  restock,
    output motor_on,
    output coin_sol,
    output busy,
    output job_done,
    output stock,
    output sold_out,
    output fault_tmo,
    output overflow
  );

endinterface

// File: rtl/aqua_job_fifo.sv
// Synchronous FIFO; a push on a full FIFO is accepted
// when a pop happens in the same cycle.
module aqua_job_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P1   = AW'(1);
  localparam logic [AW:0]   C1   = (AW+1)'(1);
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CMAX);
  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + P1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + P1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + C1;
      2'b01:   cnt_d = cnt_q - C1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/aqua_dispense_ctrl.sv
// Dispense stage: queues vend/change jobs and runs the bottle
// motor then coin-return pulses per job, tracking stock.
module aqua_dispense_ctrl
  import aqua_pkg::*;
#(
  parameter int QDEPTH      = 4,
  parameter int STOCK_INIT  = 20,
  parameter int PRICE_COINS = 3,
  parameter int MOTOR_TMO   = 200,
  parameter int SOL_ON      = 8,
  parameter int SOL_OFF     = 8
) (
  input logic                 clk,
  input logic                 rst,
  aqua_dispense_ctrl_if.slave io
);

  localparam int CM1  = (MOTOR_TMO > SOL_ON) ? MOTOR_TMO : SOL_ON;
  localparam int CMAX = (CM1 > SOL_OFF) ? CM1 : SOL_OFF;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C1       = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MOTOR_TMO - 1);
  localparam logic [CW-1:0] HI_LAST  = CW'(SOL_ON - 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(SOL_OFF - 1);
  localparam logic [7:0]    STOCK8   = 8'(STOCK_INIT);
  localparam logic [2:0]    PRICE3   = 3'(PRICE_COINS);

  disp_state_e   state_q, state_d;
  logic [2:0]    pay_q, pay_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    stock_q, stock_d;
  logic          motor_on_q, motor_on_d;
  logic          coin_sol_q, coin_sol_d;
  logic          job_done_q, job_done_d;
  logic          fault_q, fault_d;
  logic          ovf_q, ovf_d;

  logic          push_req, bad_code, stock_dec;
  logic          fifo_push, fifo_pop;
  logic          fifo_full, fifo_empty;
  job_t          wr_job, head;
  logic [$bits(job_t)-1:0] fifo_rdata;

  always_comb begin
    push_req     = io.vend || (io.change_code != CHG_NONE);
    bad_code     = (io.change_code == CHG_BAD);
    fifo_push    = push_req && !bad_code;
    fifo_pop     = (state_q == ST_POP);
    wr_job.vend  = io.vend;
    wr_job.coins = coins_of(io.change_code);
  end

  aqua_job_fifo #(
    .W     ($bits(job_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_job),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head = job_t'(fifo_rdata);

  always_comb begin
    state_d   = state_q;
    pay_d     = pay_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    stock_dec = 1'b0;
    // an illegal code or a push into a full, non-popping FIFO is lost
    ovf_d     = ovf_q || bad_code ||
                (fifo_push && fifo_full && !fifo_pop);

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_POP;
      end
      ST_POP: begin
        cnt_d = '0;
        pay_d = {1'b0, head.coins};
        if (head.vend && stock_q != 8'd0) begin
          state_d = ST_MOTOR;
        end else begin
          if (head.vend) pay_d = pay_d + PRICE3;
          state_d = (pay_d != 3'd0) ? ST_COIN_HI : ST_DONE;
        end
      end
      ST_MOTOR: begin
        if (io.bottle_seen) begin
          stock_dec = 1'b1;
          cnt_d     = '0;
          state_d   = (pay_q != 3'd0) ? ST_COIN_HI : ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          fault_d = 1'b1;
          pay_d   = pay_q + PRICE3;
          cnt_d   = '0;
          state_d = ST_COIN_HI;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      ST_COIN_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = '0;
          state_d = ST_COIN_LO;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      ST_COIN_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d   = '0;
          pay_d   = pay_q - 3'd1;
          state_d = (pay_q > 3'd1) ? ST_COIN_HI : ST_DONE;
        end else begin
          cnt_d = cnt_q + C1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    stock_d = stock_q;
    if (io.restock) begin
      stock_d = STOCK8;
    end else if (stock_dec && stock_q != 8'd0) begin
      stock_d = stock_q - 8'd1;
    end

    motor_on_d = (state_d == ST_MOTOR);
    coin_sol_d = (state_d == ST_COIN_HI);
    job_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pay_q      <= '0;
      cnt_q      <= '0;
      stock_q    <= STOCK8;
      motor_on_q <= 1'b0;
      coin_sol_q <= 1'b0;
      job_done_q <= 1'b0;
      fault_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pay_q      <= pay_d;
      cnt_q      <= cnt_d;
      stock_q    <= stock_d;
      motor_on_q <= motor_on_d;
      coin_sol_q <= coin_sol_d;
      job_done_q <= job_done_d;
      fault_q    <= fault_d;
      ovf_q      <= ovf_d;
    end
  end

  assign io.motor_on  = motor_on_q;
  assign io.coin_sol  = coin_sol_q;
  assign io.job_done  = job_done_q;
  assign io.busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign io.stock     = stock_q;
  assign io.sold_out  = (stock_q == 8'd0);
  assign io.fault_tmo = fault_q;
  assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_aqua_dispense_ctrl.sv
// Bench for aqua_dispense_ctrl: directed cases plus random
// jobs scored per job against a queue-based reference model.
module tb_aqua_dispense_ctrl;
  import aqua_pkg::*;

  localparam int QDEPTH = 4;
  localparam int SINIT  = 20;
  localparam int PRICE  = 3;
  localparam int TMO    = 200;
  localparam int SON    = 8;
  localparam int SOFF   = 8;

  logic clk = 1'b0;
  logic rst;
  logic rs_main = 1'b0;
  logic rs_mon  = 1'b0;

  aqua_dispense_ctrl_if io();

  aqua_dispense_ctrl #(
    .QDEPTH      (QDEPTH),
    .STOCK_INIT  (SINIT),
    .PRICE_COINS (PRICE),
    .MOTOR_TMO   (TMO),
    .SOL_ON      (SON),
    .SOL_OFF     (SOFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  assign io.restock = rs_main | rs_mon;

  typedef struct {
    bit vend;
    int coins;
    int delay;
    bit rs;
  } exp_job_t;

  exp_job_t q[$];
  exp_job_t j;
  int  n_chk = 0;
  int  n_err = 0;
  int  m_stock = SINIT;
  bit  m_fault = 0;
  bit  m_ovf = 0;
  bit  cur_active = 0;
  bit  prev_coin = 0;
  int  mcyc = 0, pulses = 0, hi_len = 0, lo_len = 0;
  int  excl_bad = 0, done_cnt = 0;
  int  em, ep;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int code_coins(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
  endfunction

  task automatic clear_rec();
    cur_active = 0;
    prev_coin  = 0;
    mcyc = 0;
    pulses = 0;
    hi_len = 0;
    lo_len = 0;
  endtask

  // monitor + bottle sensor: scores each job at its completion
  always @(negedge clk) begin
    rs_mon = 1'b0;
    io.bottle_seen = 1'b0;
    if (rst) begin
      clear_rec();
    end else begin
      if (io.motor_on && io.coin_sol) excl_bad++;
      if (io.motor_on) begin
        cur_active = 1;
        mcyc++;
        if (q.size() > 0 && q[0].delay == mcyc) begin
          io.bottle_seen = 1'b1;
          rs_mon = q[0].rs;
        end
      end
      if (io.job_done) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          j = q.pop_front();
          if (j.vend && m_stock > 0) begin
            if (j.delay >= 1 && j.delay <= TMO) begin
              em = j.delay;
              ep = j.coins;
              m_stock = j.rs ? SINIT : m_stock - 1;
            end else begin
              em = TMO;
              ep = j.coins + PRICE;
              m_fault = 1;
            end
          end else begin
            em = 0;
            ep = j.coins + (j.vend ? PRICE : 0);
          end
          check("motor_cycles", mcyc, em);
          check("coin_pulses", pulses, ep);
          if (ep > 0) check("coin_lo_last", lo_len, SOFF);
          check("stock", io.stock, m_stock);
          check("sold_out", io.sold_out, m_stock == 0);
          check("fault_tmo", io.fault_tmo, m_fault);
        end
        clear_rec();
      end else if (io.coin_sol) begin
        cur_active = 1;
        if (!prev_coin && pulses > 0) check("coin_lo_w", lo_len, SOFF);
        if (!prev_coin) lo_len = 0;
        hi_len++;
        prev_coin = 1;
      end else if (prev_coin) begin
        check("coin_hi_w", hi_len, SON);
        pulses++;
        hi_len = 0;
        lo_len = 1;
        prev_coin = 0;
      end else if (pulses > 0) begin
        lo_len++;
      end
    end
  end

  task automatic drive(input bit v, input logic [1:0] c,
                       input int dly, input bit rs);
    exp_job_t e;
    io.vend = v;
    io.change_code = c;
    if (c == CHG_BAD) begin
      m_ovf = 1;
    end else if (v || c != CHG_NONE) begin
      if (q.size() - (cur_active ? 1 : 0) >= QDEPTH) begin
        m_ovf = 1;
      end else begin
        e.vend = v;
        e.coins = code_coins(c);
        e.delay = dly;
        e.rs = rs;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    io.vend = 1'b0;
    io.change_code = CHG_NONE;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((io.busy || q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_time", n < max_cyc, 1);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic wait_coin(input int max_cyc);
    int n = 0;
    while (!io.coin_sol && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("coin_seen", io.coin_sol, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, g, r, dly;
    bit v;
    logic [1:0] c;
    io.vend = 1'b0;
    io.change_code = CHG_NONE;
    io.bottle_seen = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_motor", io.motor_on, 0);
    check("rst_coin", io.coin_sol, 0);
    check("rst_busy", io.busy, 0);
    check("rst_done", io.job_done, 0);
    check("rst_stock", io.stock, SINIT);
    check("rst_sold_out", io.sold_out, 0);
    check("rst_fault", io.fault_tmo, 0);
    check("rst_overflow", io.overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // vend + 5 rs, bottle after 5 motor cycles
    drive(1, CHG_5, 5, 0);
    quiet();
    wait_idle(400);
    // 10 rs change only
    drive(0, CHG_10, 0, 0);
    quiet();
    wait_idle(400);
    // restock lands in the same cycle as the decrement
    drive(1, CHG_NONE, 3, 1);
    quiet();
    wait_idle(400);
    // motor timeout
    drive(1, CHG_NONE, 0, 0);
    quiet();
    wait_idle(800);
    check("overflow_clear", io.overflow, m_ovf);

    // six pushes while a job is running
    drive(0, CHG_10, 0, 0);
    quiet();
    wait_coin(50);
    drive(1, CHG_5, 2, 0);
    drive(0, CHG_5, 0, 0);
    drive(1, CHG_10, 4, 0);
    drive(0, CHG_10, 0, 0);
    drive(1, CHG_5, 6, 0);
    drive(0, CHG_5, 0, 0);
    quiet();
    check("overflow_set", m_ovf, 1);
    wait_idle(3000);
    check("overflow_flag", io.overflow, m_ovf);

    // random jobs, kept within FIFO capacity
    for (int k = 0; k < 30; k++) begin
      v = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      c = (r < 4) ? CHG_NONE : (r < 7) ? CHG_5 : (r < 9) ? CHG_10 : CHG_BAD;
      if (!v && c == CHG_NONE) c = CHG_5;
      dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      g = 0;
      while (q.size() >= QDEPTH && g < 5000) begin
        @(negedge clk);
        g++;
      end
      drive(v, c, dly, 0);
      quiet();
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(20000);
    check("overflow_rand", io.overflow, m_ovf);

    // run stock down to zero
    g = 0;
    while (m_stock > 0 && g < 40) begin
      drive(1, CHG_NONE, 1, 0);
      quiet();
      wait_idle(400);
      g++;
    end
    check("sold_out_hit", io.sold_out, 1);
    drive(1, CHG_NONE, 1, 0);
    quiet();
    wait_idle(400);
    check("stock_zero", io.stock, 0);

    rs_main = 1'b1;
    m_stock = SINIT;
    @(negedge clk);
    rs_main = 1'b0;
    check("restock", io.stock, SINIT);
    check("restock_sold", io.sold_out, 0);

    // reset in the middle of a coin pulse with a job still queued
    drive(1, CHG_10, 2, 0);
    drive(1, CHG_5, 2, 0);
    quiet();
    wait_coin(100);
    check("pre_rst_stock", io.stock, SINIT - 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    m_stock = SINIT;
    m_fault = 0;
    m_ovf = 0;
    check("mid_rst_coin", io.coin_sol, 0);
    check("mid_rst_motor", io.motor_on, 0);
    check("mid_rst_busy", io.busy, 0);
    check("mid_rst_done", io.job_done, 0);
    check("mid_rst_stock", io.stock, SINIT);
    check("mid_rst_fault", io.fault_tmo, 0);
    check("mid_rst_ovf", io.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    check("post_rst_busy", io.busy, 0);
    check("post_rst_no_done", done_cnt - d0, 0);

    check("motor_coin_excl", excl_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
